// File: rtl/risc_fetch_unit.sv
// risc_fetch_unit: instruction fetch stage of the 32-bit RISC-V core.
// Reads the word at pc_32 from instruction memory over a req/ack handshake,
// holds it for decode under valid/ready, and pulses pc_load so that the PC
// register advances. Handles branch flushes, misaligned PCs and memory timeouts.
// Ports:
//   clk, reset (async, active-low)
//   pc_32       current PC              pc_load     one-cycle PC advance pulse
//   mem_req     memory read request     mem_addr    read address (stable in REQ)
//   mem_ack     read data strobe        mem_rdata   instruction word
//   flush       branch redirect         instr_valid / instr_ready  decode handshake
//   instr_32    fetched instruction     instr_pc_32 PC of instr_32
//   fetch_err   sticky misaligned-PC / timeout error
module risc_fetch_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_32,
  output logic              pc_load,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_32,
  output logic [ADDR_W-1:0] instr_pc_32,
  output logic              fetch_err
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [CNT_W-1:0]  tmo_cnt_d;
  logic              drop;
  logic              drop_d;
  logic              pc_load_d;
  logic              mem_req_d;
  logic              instr_valid_d;
  logic              fetch_err_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] instr_d;
  logic [ADDR_W-1:0] instr_pc_d;

  // State register; every output is also registered here from its *_d value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc_load     <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      instr_32    <= '0;
      instr_pc_32 <= '0;
      fetch_err   <= 1'b0;
      tmo_cnt     <= '0;
      drop        <= 1'b0;
    end else begin
      state       <= state_nx;
      pc_load     <= pc_load_d;
      mem_req     <= mem_req_d;
      mem_addr    <= mem_addr_d;
      instr_valid <= instr_valid_d;
      instr_32    <= instr_d;
      instr_pc_32 <= instr_pc_d;
      fetch_err   <= fetch_err_d;
      tmo_cnt     <= tmo_cnt_d;
      drop        <= drop_d;
    end
  end

  // Next state. An ack always ends the request; a flushed or previously
  // flushed request returns to IDLE so the redirected pc_32 is re-read.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = (pc_32[1:0] == 2'b00) ? REQ : ERR;
      REQ: begin
        if (mem_ack) begin
          state_nx = (drop || flush) ? IDLE : HOLD;
        end else if (tmo_cnt == CNT_LAST) begin
          state_nx = ERR;
        end
      end
      HOLD: begin
        if (flush || instr_ready) begin
          state_nx = IDLE;
        end
      end
      ERR:     state_nx = ERR;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs. Flags follow the state being
  // entered, so each output is valid in the same cycle as its state.
  always_comb begin
    pc_load_d     = 1'b0;
    mem_req_d     = (state_nx == REQ);
    instr_valid_d = (state_nx == HOLD);
    fetch_err_d   = (state_nx == ERR);
    mem_addr_d    = mem_addr;
    instr_d       = instr_32;
    instr_pc_d    = instr_pc_32;
    tmo_cnt_d     = tmo_cnt;
    drop_d        = drop;
    case (state)
      IDLE: begin
        mem_addr_d = pc_32;
        tmo_cnt_d  = '0;
        drop_d     = 1'b0;
      end
      REQ: begin
        if (mem_ack) begin
          drop_d = 1'b0;
          if (state_nx == HOLD) begin
            pc_load_d  = 1'b1;
            instr_d    = mem_rdata;
            instr_pc_d = mem_addr;
          end
        end else begin
          tmo_cnt_d = tmo_cnt + CNT_W'(1);
          // Address must stay put until the ack, so remember to discard it.
          if (flush) begin
            drop_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_risc_fetch_unit.sv
// Self-checking bench for risc_fetch_unit: directed scenarios followed by a
// randomized run scored against a transaction-level model of the fetch stream.
module tb_risc_fetch_unit;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] pc_32;
  logic              pc_load;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              flush;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_32;
  logic [ADDR_W-1:0] instr_pc_32;
  logic              fetch_err;

  logic              redir;
  logic [ADDR_W-1:0] redir_tgt;
  logic [ADDR_W-1:0] pc_init;

  int n_cmp = 0;
  int n_bad = 0;
  int pl_total = 0;
  int iv_total = 0;

  risc_fetch_unit #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_32      (pc_32),
    .pc_load    (pc_load),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .flush      (flush),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_32   (instr_32),
    .instr_pc_32(instr_pc_32),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  // PC register: redirect wins over the sequential advance.
  always @(posedge clk or negedge reset) begin
    if (!reset)        pc_32 <= pc_init;
    else if (redir)    pc_32 <= redir_tgt;
    else if (pc_load)  pc_32 <= pc_32 + 32'd4;
  end

  always @(posedge clk) begin
    if (pc_load === 1'b1)     pl_total++;
    if (instr_valid === 1'b1) iv_total++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] pc0);
    reset       = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    flush       = 1'b0;
    instr_ready = 1'b0;
    redir       = 1'b0;
    redir_tgt   = '0;
    pc_init     = pc0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    mem_ack     = 1'b1;
    mem_rdata   = 32'hDEAD_BEEF;
    flush       = 1'b0;
    instr_ready = 1'b1;
    redir       = 1'b0;
    redir_tgt   = '0;
    pc_init     = 32'h0000_0008;
    #3;
    for (int unsigned i = 0; i < 2; i++) begin
      n_cmp++;
      if ({pc_load, mem_req, instr_valid, fetch_err} !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_flags: got %b want 0000", {pc_load, mem_req, instr_valid, fetch_err});
      end
      n_cmp++;
      if ({mem_addr, instr_32, instr_pc_32} !== 96'd0) begin
        n_bad++;
        $display("FAIL reset_data: got %h/%h/%h want 0/0/0", mem_addr, instr_32, instr_pc_32);
      end
      tick();
    end
  endtask

  task automatic test_basic_fetch();
    int pl0;
    start(32'h0);
    instr_ready = 1'b1;
    tick();
    pl0 = pl_total;
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL basic_req: got req=%b addr=%h want 1/0", mem_req, mem_addr);
    end
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h0050_0093;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    n_cmp++;
    if ({instr_valid, pc_load, mem_req} !== 3'b110) begin
      n_bad++;
      $display("FAIL basic_hold_flags: got %b want 110", {instr_valid, pc_load, mem_req});
    end
    n_cmp++;
    if ({instr_32, instr_pc_32} !== {32'h0050_0093, 32'h0}) begin
      n_bad++;
      $display("FAIL basic_instr: got %h@%h want 00500093@0", instr_32, instr_pc_32);
    end
    tick();
    n_cmp++;
    if ({pc_load, instr_valid, mem_req} !== 3'b000) begin
      n_bad++;
      $display("FAIL basic_idle: got %b want 000", {pc_load, instr_valid, mem_req});
    end
    tick();
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h4}) begin
      n_bad++;
      $display("FAIL basic_next_req: got req=%b addr=%h want 1/4", mem_req, mem_addr);
    end
    n_cmp++;
    if (pl_total - pl0 !== 1) begin
      n_bad++;
      $display("FAIL basic_pc_load_count: got %0d want 1", pl_total - pl0);
    end
  endtask

  task automatic test_stall();
    int pl0;
    logic [31:0] d;
    d = $urandom;
    start(32'h100);
    tick();
    pl0 = pl_total;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = d;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      n_cmp++;
      if ({instr_valid, mem_req, instr_32, instr_pc_32} !== {2'b10, d, 32'h100}) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got v=%b req=%b %h@%h want v=1 req=0 %h@100",
                 i, instr_valid, mem_req, instr_32, instr_pc_32, d);
      end
      tick();
    end
    instr_ready = 1'b1;
    tick();
    n_cmp++;
    if ({instr_valid, mem_req} !== 2'b00) begin
      n_bad++;
      $display("FAIL stall_release: got v=%b req=%b want 0/0", instr_valid, mem_req);
    end
    tick();
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h104}) begin
      n_bad++;
      $display("FAIL stall_next_req: got req=%b addr=%h want 1/104", mem_req, mem_addr);
    end
    n_cmp++;
    if (pl_total - pl0 !== 1) begin
      n_bad++;
      $display("FAIL stall_pc_load_count: got %0d want 1", pl_total - pl0);
    end
  endtask

  task automatic test_flush_in_flight();
    int pl0;
    int iv0;
    start(32'h20);
    instr_ready = 1'b1;
    tick();
    pl0 = pl_total;
    iv0 = iv_total;
    tick();
    flush     = 1'b1;
    redir     = 1'b1;
    redir_tgt = 32'h40;
    tick();
    flush = 1'b0;
    redir = 1'b0;
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h20}) begin
      n_bad++;
      $display("FAIL flush_addr_stable: got req=%b addr=%h want 1/20", mem_req, mem_addr);
    end
    tick();
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_0BAD;
    tick();
    mem_ack   = 1'b0;
    n_cmp++;
    if ({instr_valid, pc_load, mem_req} !== 3'b000) begin
      n_bad++;
      $display("FAIL flush_dropped: got %b want 000", {instr_valid, pc_load, mem_req});
    end
    tick();
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h40}) begin
      n_bad++;
      $display("FAIL flush_new_req: got req=%b addr=%h want 1/40", mem_req, mem_addr);
    end
    n_cmp++;
    if ({pl_total - pl0, iv_total - iv0} !== {32'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL flush_counts: got pc_load=%0d valid=%0d want 0/0", pl_total - pl0, iv_total - iv0);
    end
  endtask

  task automatic test_flush_ready_same();
    int pl0;
    start(32'h80);
    instr_ready = 1'b1;
    tick();
    pl0       = pl_total;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    n_cmp++;
    if ({instr_valid, pc_load} !== 2'b11) begin
      n_bad++;
      $display("FAIL fr_hold: got v=%b pl=%b want 1/1", instr_valid, pc_load);
    end
    flush     = 1'b1;
    redir     = 1'b1;
    redir_tgt = 32'h200;
    tick();
    flush = 1'b0;
    redir = 1'b0;
    n_cmp++;
    if ({instr_valid, pc_load, mem_req} !== 3'b000) begin
      n_bad++;
      $display("FAIL fr_idle: got %b want 000", {instr_valid, pc_load, mem_req});
    end
    tick();
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h200}) begin
      n_bad++;
      $display("FAIL fr_new_req: got req=%b addr=%h want 1/200", mem_req, mem_addr);
    end
    n_cmp++;
    if (pl_total - pl0 !== 1) begin
      n_bad++;
      $display("FAIL fr_pc_load_count: got %0d want 1", pl_total - pl0);
    end
  endtask

  task automatic test_timeout();
    int n;
    start(32'h300);
    tick();
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n !== TIMEOUT) begin
      n_bad++;
      $display("FAIL timeout_req_cycles: got %0d want %0d", n, TIMEOUT);
    end
    for (int unsigned i = 0; i < 6; i++) begin
      n_cmp++;
      if ({fetch_err, mem_req, instr_valid} !== 3'b100) begin
        n_bad++;
        $display("FAIL timeout_err[%0d]: got %b want 100", i, {fetch_err, mem_req, instr_valid});
      end
      mem_ack     = $urandom_range(0, 1);
      instr_ready = $urandom_range(0, 1);
      tick();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_misaligned_and_reset();
    start(32'h2);
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({fetch_err, mem_req, pc_load} !== 3'b100) begin
        n_bad++;
        $display("FAIL misaligned[%0d]: got %b want 100", i, {fetch_err, mem_req, pc_load});
      end
    end
    start(32'h10);
    tick();
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h10}) begin
      n_bad++;
      $display("FAIL areset_pre: got req=%b addr=%h want 1/10", mem_req, mem_addr);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({pc_load, mem_req, instr_valid, fetch_err, mem_addr} !== 36'd0) begin
      n_bad++;
      $display("FAIL areset_outputs: got flags=%b addr=%h want 0000/0",
               {pc_load, mem_req, instr_valid, fetch_err}, mem_addr);
    end
  endtask

  // Model: exp_pc is the address of the next instruction that decode should
  // receive; every new request must target it, a handshake delivers
  // mem_word(exp_pc) and advances by 4, a flush redirects it.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic        exp_pl;
    logic        drop_m;
    logic        prev_req;
    logic [31:0] prev_addr;
    logic        o_req;
    logic        o_iv;
    logic [31:0] o_addr;
    int          age;
    int          lat;
    int          delivered;
    exp_pc    = 32'h1000;
    exp_pl    = 1'b0;
    drop_m    = 1'b0;
    prev_req  = 1'b0;
    prev_addr = '0;
    age       = 0;
    lat       = 1;
    delivered = 0;
    start(exp_pc);
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      o_req  = mem_req;
      o_iv   = instr_valid;
      o_addr = mem_addr;
      n_cmp++;
      if (pc_load !== exp_pl) begin
        n_bad++;
        $display("FAIL rnd_pc_load @%0d: got %b want %b", cyc, pc_load, exp_pl);
      end
      n_cmp++;
      if (fetch_err !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd_fetch_err @%0d: got %b want 0", cyc, fetch_err);
      end
      if (o_req && !prev_req) begin
        n_cmp++;
        if (o_addr !== exp_pc) begin
          n_bad++;
          $display("FAIL rnd_req_addr @%0d: got %h want %h", cyc, o_addr, exp_pc);
        end
        age = 0;
        lat = $urandom_range(1, 4);
      end else if (o_req) begin
        age++;
        n_cmp++;
        if (o_addr !== prev_addr) begin
          n_bad++;
          $display("FAIL rnd_addr_stable @%0d: got %h want %h", cyc, o_addr, prev_addr);
        end
      end

      instr_ready = ($urandom_range(0, 2) != 0);
      flush       = (o_req || o_iv) && ($urandom_range(0, 9) == 0);
      redir       = flush;
      redir_tgt   = $urandom & 32'h0000_FFFC;
      if (o_req) begin
        mem_ack   = (age == lat);
        mem_rdata = mem_word(o_addr);
      end else begin
        mem_ack   = ($urandom_range(0, 7) == 0);
        mem_rdata = $urandom;
      end

      if (o_iv && instr_ready && !flush) begin
        n_cmp++;
        if ({instr_pc_32, instr_32} !== {exp_pc, mem_word(exp_pc)}) begin
          n_bad++;
          $display("FAIL rnd_deliver @%0d: got %h@%h want %h@%h",
                   cyc, instr_32, instr_pc_32, mem_word(exp_pc), exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (flush) exp_pc = redir_tgt;

      exp_pl = o_req && mem_ack && !flush && !drop_m;
      if (o_req) begin
        if (mem_ack)    drop_m = 1'b0;
        else if (flush) drop_m = 1'b1;
      end
      prev_req  = o_req;
      prev_addr = o_addr;
      tick();
    end
    flush = 1'b0;
    redir = 1'b0;
    n_cmp++;
    if (delivered < 100) begin
      n_bad++;
      $display("FAIL rnd_delivered: got %0d want >=100", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_flush_in_flight();
    test_flush_ready_same();
    test_timeout();
    test_misaligned_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
